usb_bulk_in_mux: RTL and testbench
==================================

USB_BULK_IN_MUX -- requirements
Module: usb_bulk_in_mux

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, meaning number of AXI-stream source channels (legal range 1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning bits per beat on all streams.
REQ-003 SHALL have parameter HIGH_SPEED, default 1, meaning max packet 512 beats when 1 and 64 beats when 0.
REQ-004 SHALL have local MAX_PACKET (512 or 64) and CHAN_BITS = max(1, clog2(NUM_CHANNELS)).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clock, reset.
REQ-006 SHALL have the following ports: clock  input  1  sole clock, rising edge.
REQ-007 SHALL have: reset  input  1  asynchronous active-high reset.
REQ-008 SHALL have: s_axis_tvalid_i  input  NUM_CHANNELS  per-channel valid.
REQ-009 SHALL have: s_axis_tready_o  output  NUM_CHANNELS  per-channel ready.
REQ-010 SHALL have: s_axis_tlast_i  input  NUM_CHANNELS  per-channel end of frame.
REQ-011 SHALL have: s_axis_tdata_i  input  NUM_CHANNELS*DATA_WIDTH  channel c in bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have: m_axis_tvalid_o  output  1  merged valid.
REQ-013 SHALL have: m_axis_tready_i  input  1  merged ready.
REQ-014 SHALL have: m_axis_tlast_o  output  1  end of USB packet.
REQ-015 SHALL have: m_axis_tkeep_o  output  1  0 only on a zero-length-packet beat.
REQ-016 SHALL have: m_axis_tdata_o  output  DATA_WIDTH  merged data.
REQ-017 SHALL have: m_axis_tuser_o  output  CHAN_BITS  index of the channel owning the current beat.

Function
REQ-018 SHALL implement FSM states IDLE, XFER and ZLP.
REQ-019 In IDLE, the block SHALL grant, round-robin, the first channel with tvalid set, searching upward from (last grant + 1) mod NUM_CHANNELS; IDLE->XFER SHALL occur on the next clock, so arbitration costs exactly 1 cycle.
REQ-020 In IDLE, all s_axis_tready_o and m_axis_tvalid_o SHALL be 0.
REQ-021 In XFER, the path SHALL be combinational: m_tvalid = s_tvalid[g], m_tdata = s_tdata[g], s_tready[g] = m_tready, and other readies SHALL be 0; zero added latency.
REQ-022 A beat counter SHALL count accepted beats (tvalid&tready) within the current packet and SHALL clear on every packet end.
REQ-023 m_axis_tlast_o SHALL be s_tlast[g] OR (count == MAX_PACKET-1).
REQ-024 On an accepted beat with m_tlast=1, the FSM SHALL return to IDLE, except as in REQ-033; channels therefore interleave at packet granularity.
REQ-025 A frame longer than MAX_PACKET SHALL be split into MAX_PACKET-sized packets plus a remainder packet, with round-robin rearbitration between them.
REQ-026 m_axis_tuser_o SHALL equal the current grant index in XFER and ZLP, and SHALL be 0 in IDLE.
REQ-027 m_axis_tkeep_o SHALL be 1 in XFER.
REQ-028 While granted, a channel dropping tvalid SHALL hold the grant with no timeout.
REQ-029 When only one channel requests, it SHALL be granted regardless of the round-robin pointer.
REQ-030 With NUM_CHANNELS=1, the grant SHALL always be 0.

Reset
REQ-031 Reset SHALL force: state IDLE, grant 0, last-grant pointer NUM_CHANNELS-1 (so channel 0 wins first), counter 0, and all outputs 0 (including s_axis_tready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tkeep_o, m_axis_tuser_o).
REQ-032 Reset asserted mid-packet SHALL abort the packet immediately, with no ZLP and no tlast emitted; after release, arbitration SHALL restart from channel 0.

Configuration
REQ-033 With macro USB_BULK_MUX_ZLP_EN defined, an accepted beat with s_tlast[g]=1 and count == MAX_PACKET-1 SHALL move XFER->ZLP.
REQ-034 In ZLP, the block SHALL drive m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0 and all s_tready=0; on m_tready the FSM SHALL go to IDLE.
REQ-035 Without USB_BULK_MUX_ZLP_EN, the ZLP state SHALL be absent and the same beat SHALL return to IDLE with no extra beat.

Verification
REQ-036 Reset, then ch0 and ch2 each present a 3-beat frame together -> ch0 beats (tuser=0, tlast on beat 3), one idle cycle, ch2 beats (tuser=2).
REQ-037 HIGH_SPEED=0, ch1 sends a 150-beat frame while ch3 sends 10 beats -> packets of ch1 64, ch3 10, ch1 64, ch1 22; tlast at each packet end.
REQ-038 ZLP_EN defined, ch0 sends exactly 64 beats (HIGH_SPEED=0) -> tlast on beat 64, then one beat with tkeep=0, tlast=1, tuser=0; without the macro -> no extra beat.
REQ-039 m_tready toggles 1010... during a 5-beat ch1 frame -> data in order, no loss or duplication, s_tready[1] mirrors m_tready, other readies 0.
REQ-040 Reset pulsed at beat 3 of a 10-beat ch2 frame -> all outputs 0 the same cycle; after release, with ch0 and ch2 requesting, ch0 is granted first.

Source files
------------

// File: rtl/usb_bulk_in_mux.sv
// usb_bulk_in_mux: round-robin merge of AXI-stream channels into USB bulk-IN packets.
// Optional zero-length-packet beat after a full-size frame end: define USB_BULK_MUX_ZLP_EN.
`timescale 1ns/1ps
module usb_bulk_in_mux #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int HIGH_SPEED   = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tvalid_i,
    output logic [NUM_CHANNELS-1:0]            s_axis_tready_o,
    input  logic [NUM_CHANNELS-1:0]            s_axis_tlast_i,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata_i,
    output logic                               m_axis_tvalid_o,
    input  logic                               m_axis_tready_i,
    output logic                               m_axis_tlast_o,
    output logic                               m_axis_tkeep_o,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata_o,
    output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] m_axis_tuser_o
);

    localparam int MAX_PACKET = (HIGH_SPEED != 0) ? 512 : 64;
    localparam int CHAN_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_W      = $clog2(MAX_PACKET);
    localparam int IDX_W      = CHAN_BITS + 1;

`ifdef USB_BULK_MUX_ZLP_EN
    typedef enum logic [1:0] {IDLE, XFER, ZLP} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [CHAN_BITS-1:0] grant_q;
    logic [CHAN_BITS-1:0] last_q;
    logic [CNT_W-1:0]     count_q;

    logic                  any_req;
    logic [CHAN_BITS-1:0]  rr_pick;
    logic [IDX_W-1:0]      cand;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  cnt_max;
    logic                  pkt_last;
    logic                  beat_ok;

    // Round-robin search upward from the channel after the last grant
    always_comb begin
        any_req = 1'b0;
        rr_pick = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = {1'b0, last_q} + IDX_W'(i + 1);
            if (cand >= IDX_W'(NUM_CHANNELS)) begin
                cand = cand - IDX_W'(NUM_CHANNELS);
            end
            if (!any_req && s_axis_tvalid_i[cand[CHAN_BITS-1:0]]) begin
                any_req = 1'b1;
                rr_pick = cand[CHAN_BITS-1:0];
            end
        end
    end

    // Select the granted channel's stream signals
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (grant_q == CHAN_BITS'(c)) begin
                sel_valid = s_axis_tvalid_i[c];
                sel_last  = s_axis_tlast_i[c];
                sel_data  = s_axis_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cnt_max  = (count_q == CNT_W'(MAX_PACKET - 1));
    assign pkt_last = sel_last | cnt_max;
    assign beat_ok  = (state_q == XFER) && sel_valid && m_axis_tready_i;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, round-robin pointer and in-packet beat counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            last_q  <= CHAN_BITS'(NUM_CHANNELS - 1);
            count_q <= '0;
        end else begin
            if (state_q == IDLE && any_req) begin
                grant_q <= rr_pick;
                last_q  <= rr_pick;
            end
            if (beat_ok) begin
                count_q <= pkt_last ? '0 : count_q + CNT_W'(1);
            end
        end
    end

    // Next-state: one arbitration cycle, then stream until packet end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = XFER;
            end
            XFER: begin
                if (beat_ok && pkt_last) begin
`ifdef USB_BULK_MUX_ZLP_EN
                    if (sel_last && cnt_max) state_d = ZLP;
                    else                     state_d = IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef USB_BULK_MUX_ZLP_EN
            ZLP: begin
                if (m_axis_tready_i) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs: combinational pass-through while streaming, quiet otherwise
    always_comb begin
        s_axis_tready_o = '0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tlast_o  = 1'b0;
        m_axis_tkeep_o  = 1'b0;
        m_axis_tdata_o  = '0;
        m_axis_tuser_o  = '0;
        unique case (state_q)
            XFER: begin
                m_axis_tvalid_o = sel_valid;
                m_axis_tlast_o  = pkt_last;
                m_axis_tkeep_o  = 1'b1;
                m_axis_tdata_o  = sel_data;
                m_axis_tuser_o  = grant_q;
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    s_axis_tready_o[c] = (grant_q == CHAN_BITS'(c)) && m_axis_tready_i;
                end
            end
`ifdef USB_BULK_MUX_ZLP_EN
            ZLP: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tlast_o  = 1'b1;
                m_axis_tuser_o  = grant_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_usb_bulk_in_mux.sv
// tb_usb_bulk_in_mux: scoreboard bench for usb_bulk_in_mux (4 channels, 64-beat packets).
// Honours USB_BULK_MUX_ZLP_EN when predicting zero-length-packet beats.
`timescale 1ns/1ps
module tb_usb_bulk_in_mux;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int MAXP = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          keep;
        logic [1:0]    user;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [NCH-1:0]  s_tvalid;
    logic [NCH-1:0]  s_tready;
    logic [NCH-1:0]  s_tlast;
    logic [NCH*DW-1:0] s_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic            m_tkeep;
    logic [DW-1:0]   m_tdata;
    logic [1:0]      m_tuser;

    beat_t src_q [NCH][$];
    exp_t  exp_q [$];
    int    pk_cnt [NCH];
    int    rr_ptr;
    int    rdy_mode;
    bit    gaps;
    bit    after_last;
    logic [NCH-1:0] exp_rdy;
    int    n_cmp = 0;
    int    n_bad = 0;

    usb_bulk_in_mux #(
        .NUM_CHANNELS(NCH),
        .DATA_WIDTH  (DW),
        .HIGH_SPEED  (0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s_axis_tvalid_i(s_tvalid),
        .s_axis_tready_o(s_tready),
        .s_axis_tlast_i (s_tlast),
        .s_axis_tdata_i (s_tdata),
        .m_axis_tvalid_o(m_tvalid),
        .m_axis_tready_i(m_tready),
        .m_axis_tlast_o (m_tlast),
        .m_axis_tkeep_o (m_tkeep),
        .m_axis_tdata_o (m_tdata),
        .m_axis_tuser_o (m_tuser)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_frame(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = DW'($urandom);
            b.last = (i == len - 1);
            src_q[c].push_back(b);
        end
    endtask

    // Reference: whole packets, round-robin over channels holding data
    task automatic predict();
        beat_t mq [NCH][$];
        beat_t b;
        exp_t  e;
        int    c;
        int    n;
        bit    done;
        for (int k = 0; k < NCH; k++) mq[k] = src_q[k];
        while (1) begin
            c = -1;
            for (int k = 1; k <= NCH; k++) begin
                if (c < 0 && mq[(rr_ptr + k) % NCH].size() > 0) c = (rr_ptr + k) % NCH;
            end
            if (c < 0) break;
            n    = 0;
            done = 0;
            while (!done) begin
                b = mq[c].pop_front();
                n++;
                done   = b.last || (n == MAXP);
                e.data = b.data;
                e.last = done;
                e.keep = 1'b1;
                e.user = c[1:0];
                exp_q.push_back(e);
`ifdef USB_BULK_MUX_ZLP_EN
                if (b.last && n == MAXP) begin
                    e.data = '0;
                    e.last = 1'b1;
                    e.keep = 1'b0;
                    exp_q.push_back(e);
                end
`endif
            end
            rr_ptr = c;
        end
    endtask

    task automatic flush();
        for (int k = 0; k < NCH; k++) begin
            src_q[k].delete();
            pk_cnt[k] = 0;
        end
        exp_q.delete();
    endtask

    task automatic drain(input int budget);
        int k;
        bit busy;
        k = 0;
        busy = 1;
        while (busy && k < budget) begin
            busy = (exp_q.size() > 0);
            for (int c = 0; c < NCH; c++) if (src_q[c].size() > 0) busy = 1;
            if (busy) begin
                @(negedge clock);
                k++;
            end
        end
        n_cmp++;
        if (busy) begin
            n_bad++;
            $display("FAIL drain: %0d beats outstanding after %0d cycles, expected 0",
                     exp_q.size(), k);
        end
        flush();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        flush();
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        rr_ptr = NCH - 1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_m_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_m_tkeep"},  32'(m_tkeep),  32'd0);
        chk({tag, "_m_tuser"},  32'(m_tuser),  32'd0);
        chk({tag, "_m_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    endtask

    // Source drivers: valid held while a packet is due, gaps only mid-packet
    initial begin
        beat_t b;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        forever begin
            @(negedge clock);
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            for (int c = 0; c < NCH; c++) begin
                if (src_q[c].size() > 0) begin
                    s_tvalid[c] = (pk_cnt[c] == 0 || !gaps) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    s_tlast[c]  = src_q[c][0].last;
                    s_tdata[c*DW +: DW] = src_q[c][0].data;
                end else begin
                    s_tvalid[c] = 1'b0;
                    s_tlast[c]  = 1'b0;
                    s_tdata[c*DW +: DW] = '0;
                end
            end
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (s_tvalid[c] && s_tready[c] && src_q[c].size() > 0) begin
                    b = src_q[c].pop_front();
                    pk_cnt[c]++;
                    if (b.last || pk_cnt[c] == MAXP) pk_cnt[c] = 0;
                end
            end
        end
    end

    // Monitor: compare every merged beat against the scoreboard
    initial begin
        exp_t e;
        after_last = 0;
        forever begin
            @(negedge clock);
            #1;
            if (reset) begin
                after_last = 0;
            end else begin
                if (after_last) begin
                    after_last = 0;
                    if (exp_q.size() == 0 || exp_q[0].keep)
                        chk("arb_gap_tvalid", 32'(m_tvalid), 32'd0);
                end
                if (m_tvalid) begin
                    exp_rdy = '0;
                    if (exp_q.size() > 0 && exp_q[0].keep && m_tready)
                        exp_rdy = NCH'(1) << exp_q[0].user;
                    chk("s_tready", 32'(s_tready), 32'(exp_rdy));
                end
                if (m_tvalid && m_tready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL beat: got unexpected beat tuser=%0d tdata=%0h, expected none",
                                 m_tuser, m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", 32'(m_tdata), 32'(e.data));
                        chk("tlast", 32'(m_tlast), 32'(e.last));
                        chk("tkeep", 32'(m_tkeep), 32'(e.keep));
                        chk("tuser", 32'(m_tuser), 32'(e.user));
                        if (e.last) after_last = 1;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        int nf;
        int len;
        reset    = 1'b1;
        rdy_mode = 0;
        gaps     = 0;
        rr_ptr   = NCH - 1;
        for (int c = 0; c < NCH; c++) pk_cnt[c] = 0;
        #2;
        chk_quiet("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Two simultaneous 3-beat frames
        load_frame(0, 3);
        load_frame(2, 3);
        predict();
        drain(500);

        // Long frame split against a short competitor
        do_reset();
        load_frame(1, 150);
        load_frame(3, 10);
        predict();
        drain(2000);

        // Exactly one full packet
        do_reset();
        load_frame(0, 64);
        predict();
        drain(500);

        // Alternating sink ready
        do_reset();
        rdy_mode = 1;
        load_frame(1, 5);
        predict();
        drain(500);
        rdy_mode = 0;

        // Reset in the middle of a frame
        do_reset();
        load_frame(2, 10);
        predict();
        k = 0;
        while (exp_q.size() > 8 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("pre_reset_beats_left", 32'(exp_q.size()), 32'd8);
        reset = 1'b1;
        #1;
        chk_quiet("midreset");
        flush();
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        rr_ptr = NCH - 1;
        load_frame(0, 4);
        load_frame(2, 4);
        predict();
        drain(500);

        // Randomized traffic with back-pressure and source gaps
        rdy_mode = 2;
        gaps     = 1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    nf = $urandom_range(1, 2);
                    for (int f = 0; f < nf; f++) begin
                        case ($urandom_range(0, 3))
                            0:       len = 64;
                            1:       len = 128;
                            2:       len = $urandom_range(1, 10);
                            default: len = $urandom_range(1, 150);
                        endcase
                        load_frame(c, len);
                    end
                end
            end
            predict();
            drain(20000);
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
